hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Pipeline control block that consumes the stage-register outputs (ID, EX, MEM, WB fields) and drives the load-enable and clear inputs back into the IF/ID and ID/EX pipeline registers. It resolves data hazards for the SPARC 5-stage pipeline. It selects operand forwarding sources for rs1, rs2 and store-data rd, and inserts a single-cycle bubble on load-use. It also squashes the delay-slot instruction on annulled branches and keeps saturating stall and annul event counters for debug.

## Interface
- CNT_W, 16, width of the stall and annul event counters.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset; synchronous, active-high.
- cnt_clr  in  1  synchronous clear of both counters.
- ID_rs1, ID_rs2, ID_rd  in  5 each  source register fields of the instruction in ID.
- ID_uses_rs1, ID_uses_rs2, ID_uses_rd  in  1 each  the matching field is a real source. ID_uses_rd is set for stores.
- ID_branch, ID_branch_taken, ID_branch_always, ID_annul  in  1 each  Bicc decoded in ID: is branch, condition true, BA, a-bit.
- EX_RD_instr  in  5  destination in EX.
- EX_RF_enable  in  1  EX writes the register file.
- EX_is_load  in  1  EX instruction is a load.
- MEM_RD_instr  in  5  destination in MEM.
- MEM_RF_enable  in  1  MEM writes the register file.
- WB_RD_instr  in  5  destination in WB.
- WB_RF_enable  in  1  WB writes the register file.
- PC_LE, nPC_LE  out  1 each  PC and nPC load enables.
- IF_ID_LE  out  1  IF/ID load enable.
- IF_ID_clr  out  1  IF/ID synchronous clear; loads a NOP.
- ID_EX_clr  out  1  ID/EX clear; inserts a bubble.
- fwd_sel_rs1, fwd_sel_rs2, fwd_sel_rd  out  2 each  operand source select: 00 register file, 01 EX ALU out, 10 MEM mux out, 11 WB data.
- stall_count, annul_count  out  CNT_W each  saturating event counters.

## Operation
- **Forwarding** (combinational). The select for field f is computed from the `match` predicates:
  - match_X = (X_RD_instr == f) & X_RF_enable & (f != 0).
  - The select is EX if match_EX, else MEM if match_MEM, else WB if match_WB, else 00.
  - Register %g0 (f = 0) always gets 00. The `ID_uses_*` flags do not gate the selects.
- **Load-use detect**:
  - lu = EX_is_load & EX_RF_enable & (EX_RD_instr != 0) & ((ID_uses_rs1 & EX_RD_instr == ID_rs1) | (ID_uses_rs2 & EX_RD_instr == ID_rs2) | (ID_uses_rd & EX_RD_instr == ID_rd)).
- **Annul condition**: an = ID_branch & ID_annul & (~ID_branch_taken | ID_branch_always).
- **FSM states**: RUN and STALL.
  - In RUN with lu=1: stall = 1, next state STALL.
  - In RUN with lu=0: next state RUN.
  - STALL is left unconditionally; the next state is RUN.
  - In STALL, stall is forced to 0. EX holds a bubble, so this instruction's load-use is never counted twice.
- **Stall outputs**: stall = 1 gives PC_LE = nPC_LE = IF_ID_LE = 0 and ID_EX_clr = 1. Otherwise all three LEs are 1 and ID_EX_clr = 0.
- **Annul outputs**: IF_ID_clr = an & ~stall. The delay slot being fetched is loaded as a NOP.
- **Stall and annul in the same cycle**: the stall wins. The branch stays in ID, and the annul fires once, on the cycle it advances (the STALL state).
- **Counters**: stall_count += 1 on each stall cycle; annul_count += 1 on each cycle with IF_ID_clr = 1 outside reset. Both saturate at 2^CNT_W − 1. cnt_clr takes priority over increment.
- **Reset**:
  - While reset = 1, state ← RUN and both counters ← 0.
  - PC_LE = nPC_LE = IF_ID_LE = 0, IF_ID_clr = 1, ID_EX_clr = 1, all fwd_sel = 00.

## Timing
- Forward selects, LEs and clears are combinational from the current inputs and state, and are valid within the same cycle. Zero latency.
- A load-use stall lasts exactly one cycle per load. On the next edge the load is in MEM, and its data is forwarded via sel 10.
- State and counters update on posedge.
- Asserting reset mid-stall:
  - Leaves the FSM in RUN on the next edge.
  - Holds outputs at their reset values for the whole reset window.
  - The first cycle after reset deasserts is a normal RUN cycle.

## Test plan
- **Reset**: hold reset for 2 cycles with lu conditions present → IF_ID_clr = 1, ID_EX_clr = 1, all LEs 0, counters 0. Release → LEs 1, clears 0 when there is no hazard.
- **Forwarding priority**: ID_rs1 = 5 with EX, MEM and WB RD all 5 and all enabled → fwd_sel_rs1 = 01.
  - Drop EX_RF_enable → 10; drop MEM_RF_enable → 11.
  - ID_rs1 = 0 with all stages matching → 00.
- **Load-use**: EX_is_load = 1, EX_RD_instr = 7, ID_rs2 = 7, ID_uses_rs2 = 1 → one cycle of PC_LE = IF_ID_LE = 0 and ID_EX_clr = 1, stall_count 0 → 1. Hold the inputs for the next cycle → no stall (state STALL), stall_count stays 1.
- **Annul**:
  - branch = 1, annul = 1, taken = 0 → IF_ID_clr = 1, annul_count += 1.
  - taken = 1, always = 0 → IF_ID_clr = 0.
  - taken = 1, always = 1 → IF_ID_clr = 1.
- **Stall with annul**: a load-use and an annulling branch together in ID → cycle 1: stall only, IF_ID_clr = 0. Cycle 2: IF_ID_clr = 1, annul_count incremented once.
- **Saturation and clear**, with CNT_W = 4: 20 stall events → stall_count = 15 and holds there. Pulse cnt_clr together with a stall → stall_count = 0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the SPARC 5-stage pipeline.
// Picks operand sources, stalls on load-use, annuls delay slots, counts events.
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_clr,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_uses_rd,
    input  logic             ID_branch,
    input  logic             ID_branch_taken,
    input  logic             ID_branch_always,
    input  logic             ID_annul,
    input  logic [4:0]       EX_RD_instr,
    input  logic             EX_RF_enable,
    input  logic             EX_is_load,
    input  logic [4:0]       MEM_RD_instr,
    input  logic             MEM_RF_enable,
    input  logic [4:0]       WB_RD_instr,
    input  logic             WB_RF_enable,
    output logic             PC_LE,
    output logic             nPC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_clr,
    output logic             ID_EX_clr,
    output logic [1:0]       fwd_sel_rs1,
    output logic [1:0]       fwd_sel_rs2,
    output logic [1:0]       fwd_sel_rd,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] annul_count
);

    typedef enum logic {RUN, STALL} state_t;

    state_t state;
    logic   lu;
    logic   an;
    logic   stall;
    logic   annul_ev;

    // Youngest writer wins; %g0 never forwards.
    function automatic logic [1:0] pick_src(
        input logic [4:0] f,
        input logic [4:0] ex_rd,
        input logic       ex_en,
        input logic [4:0] mem_rd,
        input logic       mem_en,
        input logic [4:0] wb_rd,
        input logic       wb_en
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (f != 5'd0) begin
            if (ex_en && ex_rd == f)
                sel = 2'b01;
            else if (mem_en && mem_rd == f)
                sel = 2'b10;
            else if (wb_en && wb_rd == f)
                sel = 2'b11;
        end
        return sel;
    endfunction

    // Hazard predicates from the current stage contents.
    always_comb begin
        lu = EX_is_load && EX_RF_enable && (EX_RD_instr != 5'd0) &&
             ((ID_uses_rs1 && EX_RD_instr == ID_rs1) ||
              (ID_uses_rs2 && EX_RD_instr == ID_rs2) ||
              (ID_uses_rd  && EX_RD_instr == ID_rd));
        an = ID_branch && ID_annul &&
             (!ID_branch_taken || ID_branch_always);
        stall    = (state == RUN) && lu && !reset;
        annul_ev = an && !stall && !reset;
    end

    // Pipeline register controls and forward selects; reset forces a flush.
    always_comb begin
        PC_LE       = 1'b0;
        nPC_LE      = 1'b0;
        IF_ID_LE    = 1'b0;
        IF_ID_clr   = 1'b1;
        ID_EX_clr   = 1'b1;
        fwd_sel_rs1 = 2'b00;
        fwd_sel_rs2 = 2'b00;
        fwd_sel_rd  = 2'b00;
        if (!reset) begin
            PC_LE       = !stall;
            nPC_LE      = !stall;
            IF_ID_LE    = !stall;
            IF_ID_clr   = annul_ev;
            ID_EX_clr   = stall;
            fwd_sel_rs1 = pick_src(ID_rs1, EX_RD_instr, EX_RF_enable,
                                   MEM_RD_instr, MEM_RF_enable,
                                   WB_RD_instr, WB_RF_enable);
            fwd_sel_rs2 = pick_src(ID_rs2, EX_RD_instr, EX_RF_enable,
                                   MEM_RD_instr, MEM_RF_enable,
                                   WB_RD_instr, WB_RF_enable);
            fwd_sel_rd  = pick_src(ID_rd, EX_RD_instr, EX_RF_enable,
                                   MEM_RD_instr, MEM_RF_enable,
                                   WB_RD_instr, WB_RF_enable);
        end
    end

    // Stall FSM: one bubble per load, then back to RUN.
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= stall ? STALL : RUN;
    end

    // Saturating debug counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_count <= '0;
            annul_count <= '0;
        end else begin
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (annul_ev && annul_count != '1)
                annul_count <= annul_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with 4-bit counters.
// Hand-computed expectations for forwarding, stalls, annuls and saturation.
module tb_hazard_forward_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             cnt_clr;
    logic [4:0]       ID_rs1, ID_rs2, ID_rd;
    logic             ID_uses_rs1, ID_uses_rs2, ID_uses_rd;
    logic             ID_branch, ID_branch_taken;
    logic             ID_branch_always, ID_annul;
    logic [4:0]       EX_RD_instr;
    logic             EX_RF_enable, EX_is_load;
    logic [4:0]       MEM_RD_instr;
    logic             MEM_RF_enable;
    logic [4:0]       WB_RD_instr;
    logic             WB_RF_enable;
    logic             PC_LE, nPC_LE, IF_ID_LE;
    logic             IF_ID_clr, ID_EX_clr;
    logic [1:0]       fwd_sel_rs1, fwd_sel_rs2, fwd_sel_rd;
    logic [CNT_W-1:0] stall_count, annul_count;

    int n_chk  = 0;
    int n_pass = 0;

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .cnt_clr          (cnt_clr),
        .ID_rs1           (ID_rs1),
        .ID_rs2           (ID_rs2),
        .ID_rd            (ID_rd),
        .ID_uses_rs1      (ID_uses_rs1),
        .ID_uses_rs2      (ID_uses_rs2),
        .ID_uses_rd       (ID_uses_rd),
        .ID_branch        (ID_branch),
        .ID_branch_taken  (ID_branch_taken),
        .ID_branch_always (ID_branch_always),
        .ID_annul         (ID_annul),
        .EX_RD_instr      (EX_RD_instr),
        .EX_RF_enable     (EX_RF_enable),
        .EX_is_load       (EX_is_load),
        .MEM_RD_instr     (MEM_RD_instr),
        .MEM_RF_enable    (MEM_RF_enable),
        .WB_RD_instr      (WB_RD_instr),
        .WB_RF_enable     (WB_RF_enable),
        .PC_LE            (PC_LE),
        .nPC_LE           (nPC_LE),
        .IF_ID_LE         (IF_ID_LE),
        .IF_ID_clr        (IF_ID_clr),
        .ID_EX_clr        (ID_EX_clr),
        .fwd_sel_rs1      (fwd_sel_rs1),
        .fwd_sel_rs2      (fwd_sel_rs2),
        .fwd_sel_rd       (fwd_sel_rd),
        .stall_count      (stall_count),
        .annul_count      (annul_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic chk_ctl(input string tag, input logic le,
                           input logic ifc, input logic idc);
        check({tag, ".PC_LE"}, 32'(PC_LE), 32'(le));
        check({tag, ".nPC_LE"}, 32'(nPC_LE), 32'(le));
        check({tag, ".IF_ID_LE"}, 32'(IF_ID_LE), 32'(le));
        check({tag, ".IF_ID_clr"}, 32'(IF_ID_clr), 32'(ifc));
        check({tag, ".ID_EX_clr"}, 32'(ID_EX_clr), 32'(idc));
    endtask

    task automatic chk_cnt(input string tag, input int sc, input int ac);
        check({tag, ".stall_count"}, 32'(stall_count), 32'(sc));
        check({tag, ".annul_count"}, 32'(annul_count), 32'(ac));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        cnt_clr = 0;
        ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0;
        ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_uses_rd = 0;
        ID_branch = 0; ID_branch_taken = 0;
        ID_branch_always = 0; ID_annul = 0;
        EX_RD_instr = 0; EX_RF_enable = 0; EX_is_load = 0;
        MEM_RD_instr = 0; MEM_RF_enable = 0;
        WB_RD_instr = 0; WB_RF_enable = 0;
    endtask

    task automatic set_lu();
        EX_is_load = 1; EX_RF_enable = 1; EX_RD_instr = 7;
        ID_rs2 = 7; ID_uses_rs2 = 1;
    endtask

    initial begin
        clear_in();
        reset = 1;
        set_lu();
        #1;
        chk_ctl("rst0", 0, 1, 1);
        check("rst0.fwd_rs2", 32'(fwd_sel_rs2), 32'd0);
        step();
        chk_ctl("rst1", 0, 1, 1);
        chk_cnt("rst1", 0, 0);
        step();
        chk_ctl("rst2", 0, 1, 1);
        chk_cnt("rst2", 0, 0);
        reset = 0;
        clear_in();
        #1;
        chk_ctl("run", 1, 0, 0);

        ID_rs1 = 5;
        EX_RD_instr = 5;  EX_RF_enable = 1;
        MEM_RD_instr = 5; MEM_RF_enable = 1;
        WB_RD_instr = 5;  WB_RF_enable = 1;
        #1 check("fwd_ex", 32'(fwd_sel_rs1), 32'd1);
        EX_RF_enable = 0;
        #1 check("fwd_mem", 32'(fwd_sel_rs1), 32'd2);
        MEM_RF_enable = 0;
        #1 check("fwd_wb", 32'(fwd_sel_rs1), 32'd3);
        WB_RF_enable = 0;
        #1 check("fwd_rf", 32'(fwd_sel_rs1), 32'd0);
        EX_RF_enable = 1; MEM_RF_enable = 1; WB_RF_enable = 1;
        ID_rs1 = 0;
        EX_RD_instr = 0; MEM_RD_instr = 0; WB_RD_instr = 0;
        #1 check("fwd_g0", 32'(fwd_sel_rs1), 32'd0);
        EX_RD_instr = 9; MEM_RD_instr = 6; WB_RD_instr = 3;
        ID_rs1 = 9; ID_rs2 = 6; ID_rd = 3;
        #1;
        check("fwd_rs1_ex", 32'(fwd_sel_rs1), 32'd1);
        check("fwd_rs2_mem", 32'(fwd_sel_rs2), 32'd2);
        check("fwd_rd_wb", 32'(fwd_sel_rd), 32'd3);
        chk_ctl("fwd_nostall", 1, 0, 0);
        clear_in();

        set_lu();
        #1;
        chk_ctl("lu0", 0, 0, 1);
        check("lu0.fwd_rs2", 32'(fwd_sel_rs2), 32'd1);
        step();
        chk_cnt("lu1", 1, 0);
        chk_ctl("lu1", 1, 0, 0);
        step();
        chk_cnt("lu2", 1, 0);
        clear_in();
        #1 chk_ctl("lu_done", 1, 0, 0);

        ID_branch = 1; ID_annul = 1;
        #1 chk_ctl("an_nt", 1, 1, 0);
        step();
        chk_cnt("an_nt", 1, 1);
        ID_branch_taken = 1;
        #1 chk_ctl("an_t", 1, 0, 0);
        step();
        chk_cnt("an_t", 1, 1);
        ID_branch_always = 1;
        #1 chk_ctl("an_ba", 1, 1, 0);
        step();
        chk_cnt("an_ba", 1, 2);
        ID_annul = 0;
        #1 chk_ctl("an_noa", 1, 0, 0);
        clear_in();

        set_lu();
        ID_branch = 1; ID_annul = 1;
        #1 chk_ctl("sa1", 0, 0, 1);
        step();
        chk_cnt("sa1", 2, 2);
        chk_ctl("sa2", 1, 1, 0);
        step();
        chk_cnt("sa2", 2, 3);
        clear_in();

        set_lu();
        for (int i = 0; i < 20; i++) begin
            step();
            step();
        end
        chk_cnt("sat", 15, 3);
        step();
        step();
        check("sat_hold", 32'(stall_count), 32'd15);
        cnt_clr = 1;
        #1 chk_ctl("clr", 0, 0, 1);
        step();
        chk_cnt("clr", 0, 0);
        cnt_clr = 0;

        reset = 1;
        #1 chk_ctl("mid_rst", 0, 1, 1);
        step();
        chk_cnt("mid_rst", 0, 0);
        chk_ctl("mid_rst2", 0, 1, 1);
        reset = 0;
        #1 chk_ctl("post_rst", 0, 0, 1);
        step();
        chk_cnt("post_rst", 1, 0);
        clear_in();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
